// File: rtl/tilemap_blit.sv
// Tilemap rectangle blitter: CPU-programmed FILL/SEQUENCE writes into the tilemap index RAM.
// Optional `TILEMAP_BLIT_WRAP_EN: coordinates wrap around the map instead of clipping.
module tilemap_blit #(
    parameter int         TILEMAP_RAM_WIDTH = 10,
    parameter logic [4:0] TILEMAP_CELLS_X   = 5'd22,
    parameter logic [4:0] TILEMAP_CELLS_Y   = 5'd17
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [2:0]                   addr,
    input  logic [7:0]                   data_in,
    input  logic                         write,
    output logic [7:0]                   data_out,
    output logic                         ram_req,
    input  logic                         ram_gnt,
    output logic [TILEMAP_RAM_WIDTH-1:0] ram_addr,
    output logic                         ram_wr,
    output logic [7:0]                   ram_data,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [7:0] idx_q, idx_d, step_q, step_d;
    logic [1:0] cmd_q, cmd_d;
    logic       clipped_q, clipped_d;

    // Shadows of the running operation
    logic [4:0] cx_q, cx_d, cy_q, cy_d, x0_q, x0_d;
    logic [4:0] wl_q, wl_d, hl_q, hl_d, col_q, col_d, row_q, row_d;
    logic [7:0] cur_q, cur_d, stp_q, stp_d;
    logic       clip_pend_q, clip_pend_d;

    logic [4:0] wlen, hlen, x0, y0;
    logic       empty, clip;

`ifdef TILEMAP_BLIT_WRAP_EN
    assign wlen  = (w_q > {3'b0, TILEMAP_CELLS_X}) ? TILEMAP_CELLS_X : w_q[4:0];
    assign hlen  = (h_q > {3'b0, TILEMAP_CELLS_Y}) ? TILEMAP_CELLS_Y : h_q[4:0];
    assign x0    = 5'(x_q % {3'b0, TILEMAP_CELLS_X});
    assign y0    = 5'(y_q % {3'b0, TILEMAP_CELLS_Y});
    assign empty = (w_q == 8'd0) || (h_q == 8'd0);
    assign clip  = (w_q > {3'b0, TILEMAP_CELLS_X}) || (h_q > {3'b0, TILEMAP_CELLS_Y});
`else
    logic [8:0] sum_x, sum_y;
    assign sum_x = {1'b0, x_q} + {1'b0, w_q};
    assign sum_y = {1'b0, y_q} + {1'b0, h_q};
    // Lengths are only consumed when the start lies inside the map, so 5 bits suffice
    assign wlen  = (sum_x > {4'b0, TILEMAP_CELLS_X}) ? TILEMAP_CELLS_X - x_q[4:0] : w_q[4:0];
    assign hlen  = (sum_y > {4'b0, TILEMAP_CELLS_Y}) ? TILEMAP_CELLS_Y - y_q[4:0] : h_q[4:0];
    assign x0    = x_q[4:0];
    assign y0    = y_q[4:0];
    assign empty = (w_q == 8'd0) || (h_q == 8'd0) ||
                   (x_q >= {3'b0, TILEMAP_CELLS_X}) || (y_q >= {3'b0, TILEMAP_CELLS_Y});
    assign clip  = (sum_x > {4'b0, TILEMAP_CELLS_X}) || (sum_y > {4'b0, TILEMAP_CELLS_Y});
`endif

    logic [4:0] cx_nx, cy_nx;
    assign cx_nx = (cx_q == TILEMAP_CELLS_X - 5'd1) ? '0 : cx_q + 5'd1;
    assign cy_nx = (cy_q == TILEMAP_CELLS_Y - 5'd1) ? '0 : cy_q + 5'd1;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        w_d         = w_q;
        h_d         = h_q;
        idx_d       = idx_q;
        step_d      = step_q;
        cmd_d       = cmd_q;
        clipped_d   = clipped_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        x0_d        = x0_q;
        wl_d        = wl_q;
        hl_d        = hl_q;
        col_d       = col_q;
        row_d       = row_q;
        cur_d       = cur_q;
        stp_d       = stp_q;
        clip_pend_d = clip_pend_q;

        if (write) begin
            case (addr)
                3'd0:    x_d    = data_in;
                3'd1:    y_d    = data_in;
                3'd2:    w_d    = data_in;
                3'd3:    h_d    = data_in;
                3'd4:    idx_d  = data_in;
                3'd5:    step_d = data_in;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (write && addr == 3'd6 && (data_in == 8'd1 || data_in == 8'd2)) begin
                    cmd_d   = data_in[1:0];
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cx_d        = x0;
                cy_d        = y0;
                x0_d        = x0;
                wl_d        = wlen;
                hl_d        = hlen;
                col_d       = '0;
                row_d       = '0;
                cur_d       = idx_q;
                stp_d       = step_q;
                clip_pend_d = clip;
                if (empty) begin
                    clipped_d = clip;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (ram_gnt) begin
                    if (cmd_q == 2'd2) cur_d = cur_q + stp_q;
                    if (col_q + 5'd1 == wl_q) begin
                        col_d = '0;
                        cx_d  = x0_q;
                        row_d = row_q + 5'd1;
                        cy_d  = cy_nx;
                        if (row_q + 5'd1 == hl_q) begin
                            clipped_d = clip_pend_q;
                            state_d   = S_DONE;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                        cx_d  = cx_nx;
                    end
                end
            end
            S_DONE: begin
                cmd_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            idx_q       <= '0;
            step_q      <= '0;
            cmd_q       <= '0;
            clipped_q   <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            x0_q        <= '0;
            wl_q        <= '0;
            hl_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cur_q       <= '0;
            stp_q       <= '0;
            clip_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            idx_q       <= idx_d;
            step_q      <= step_d;
            cmd_q       <= cmd_d;
            clipped_q   <= clipped_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            x0_q        <= x0_d;
            wl_q        <= wl_d;
            hl_q        <= hl_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cur_q       <= cur_d;
            stp_q       <= stp_d;
            clip_pend_q <= clip_pend_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign ram_req  = (state_q == S_WRITE);
    assign ram_wr   = ram_req && ram_gnt;
    assign ram_addr = TILEMAP_RAM_WIDTH'({cy_q, cx_q});
    assign ram_data = cur_q;

    always_comb begin
        case (addr)
            3'd0:    data_out = x_q;
            3'd1:    data_out = y_q;
            3'd2:    data_out = w_q;
            3'd3:    data_out = h_q;
            3'd4:    data_out = idx_q;
            3'd5:    data_out = step_q;
            3'd6:    data_out = {6'b0, cmd_q};
            default: data_out = {6'b0, clipped_q, busy};
        endcase
    end

endmodule
